fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C000000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1, which blocks request advance.
REQ-005 SHALL have port redirect_valid, input, 1, a backend/branch-unit redirect.
REQ-006 SHALL have port redirect_pc, input, 32, the redirect target.
REQ-007 SHALL have port bp_hit, input, 1, predictor hit for the current fetch_pc (combinational lookup, pure function of fetch_pc).
REQ-008 SHALL have port bp_slot, input, 2, the slot (0-3) of the predicted-taken branch in the 16-byte group.
REQ-009 SHALL have port bp_target, input, 32, the predicted target.
REQ-010 SHALL have port ifu_ready, input, 1, meaning the fetch buffer can accept a request.
REQ-011 SHALL have port pc_valid, output, 1, meaning a fetch request is presented.
REQ-012 SHALL have port fetch_pc, output, 32, the request address, bits [1:0] always 0.
REQ-013 SHALL have port cut_pos, output, 2, the instruction count in the group: 00=4, 01=1, 10=2, 11=3.
REQ-014 SHALL have port pred_taken, output, 1, meaning the group ends in a predicted-taken branch.
REQ-015 SHALL have port pred_jump_target_pc, output, 32, the predicted target (0 when pred_taken=0).
REQ-016 SHALL have port misalign_err, output, 1, set when the last redirect address had nonzero bits [1:0].

Function
REQ-017 SHALL implement FSM states BOOT, RUN, REDIR; pc_valid=1 only in RUN.
REQ-018 SHALL transition BOOT->RUN on the first clock edge after rst deasserts.
REQ-019 SHALL transition REDIR->RUN after exactly one cycle.
REQ-020 SHALL transition any state->REDIR on redirect_valid, regardless of stall or ifu_ready.
REQ-021 SHALL define the start slot as s0=fetch_pc[3:2].
REQ-022 SHALL compute effective hit eh = bp_hit && (bp_slot >= s0); a hit with bp_slot < s0 is ignored.
REQ-023 SHALL compute count = eh ? (bp_slot - s0 + 1) : (4 - s0), with cut_pos = count[1:0].
REQ-024 SHALL derive pred_taken=eh and pred_jump_target_pc = eh ? {bp_target[31:2],2'b00} : 0, combinationally from fetch_pc and bp_*.
REQ-025 SHALL complete a transfer in a cycle where pc_valid && ifu_ready && !stall && !redirect_valid.
REQ-026 SHALL, on transfer, load next fetch_pc = eh ? {bp_target[31:2],2'b00} : {fetch_pc[31:4]+1, 4'b0000}.
REQ-027 SHALL let the sequential increment wrap: 32'hFFFFFFF0 -> 32'h00000000.
REQ-028 SHALL hold fetch_pc, pc_valid and derived outputs stable while pc_valid && (!ifu_ready || stall); there is no combinational path from ifu_ready to pc_valid.
REQ-029 SHALL, on redirect_valid, load fetch_pc <= {redirect_pc[31:2],2'b00} and misalign_err <= |redirect_pc[1:0]; any pending request is dropped, not transferred.
REQ-030 SHALL give redirect_valid priority over a simultaneous transfer; no transfer occurs that cycle.
REQ-031 SHALL apply the later redirect when redirects arrive back-to-back, remaining in REDIR one cycle after the last.
REQ-032 SHALL take a redirect during stall immediately; the new request then waits for stall=0.

Reset
REQ-033 SHALL, while rst=1, force state=BOOT, fetch_pc=RESET_PC, pc_valid=0, misalign_err=0, independent of clk.
REQ-034 SHALL, on rst asserted mid-operation, abandon the pending request with no transfer, and restart from RESET_PC.

Verification
REQ-035 Reset then ifu_ready=1, bp_hit=0: pc_valid=1 one cycle after release; fetch_pc sequence 1C000000, 1C000010, 1C000020; cut_pos=00 each.
REQ-036 Redirect to 1C000108, bp_hit=0: one bubble cycle, then fetch_pc=1C000108, cut_pos=10 (2 instr); next fetch_pc=1C000110.
REQ-037 fetch_pc=1C000104, bp_hit=1, bp_slot=3, bp_target=1C002000: cut_pos=11, pred_taken=1, next fetch_pc=1C002000.
REQ-038 fetch_pc=1C00010C with bp_slot=1 hit: hit ignored, cut_pos=01, pred_taken=0, next fetch_pc=1C000110.
REQ-039 ifu_ready=0 for 5 cycles then 1: fetch_pc held 5 cycles, single advance afterwards. Stall=1 with redirect 0000_2003: fetch_pc=00002000, misalign_err=1, no transfer until stall=0.
REQ-040 fetch_pc=FFFFFFF0, no hit, transfer: next fetch_pc=00000000; rst pulse mid-hold: fetch_pc=1C000000, pc_valid=0 immediately.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch request bundle between the PC generator and its environment
// (redirect source, branch predictor, fetch buffer).
interface fetch_pc_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        bp_hit;
    logic [1:0]  bp_slot;
    logic [31:0] bp_target;
    logic        ifu_ready;
    logic        pc_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  cut_pos;
    logic        pred_taken;
    logic [31:0] pred_jump_target_pc;
    logic        misalign_err;

    modport master (
        input  stall, redirect_valid, redirect_pc, bp_hit, bp_slot, bp_target, ifu_ready,
        output pc_valid, fetch_pc, cut_pos, pred_taken, pred_jump_target_pc, misalign_err
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, bp_hit, bp_slot, bp_target, ifu_ready,
        input  pc_valid, fetch_pc, cut_pos, pred_taken, pred_jump_target_pc, misalign_err
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues 16-byte fetch groups, trims them at predicted-taken
// branches and follows backend redirects.
//
// state | meaning
// BOOT  | leaving reset, no request presented
// RUN   | request presented on fetch_pc (pc_valid=1)
// REDIR | one-cycle bubble after a redirect
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic   clk,
    input  logic   rst,
    fetch_pc_if.master bus
);

    typedef enum logic [1:0] {BOOT, RUN, REDIR} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic        err_q;
    logic [1:0]  s0;
    logic        eh;
    logic [2:0]  count;
    logic        xfer;
    logic [31:0] seq_pc;
    logic [31:0] tgt_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.redirect_valid) begin
            state_nxt = REDIR;
        end else begin
            case (state)
                BOOT:    state_nxt = RUN;
                REDIR:   state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_comb begin
        bus.pc_valid            = (state == RUN);
        bus.fetch_pc            = pc_q;
        bus.misalign_err        = err_q;
        bus.cut_pos             = count[1:0];
        bus.pred_taken          = eh;
        bus.pred_jump_target_pc = eh ? tgt_pc : 32'h0;
    end

    // Slots before the fetch start are not part of this group, so a hit there is stale.
    assign s0     = pc_q[3:2];
    assign eh     = bus.bp_hit && (bus.bp_slot >= s0);
    assign count  = eh ? ({1'b0, bus.bp_slot} - {1'b0, s0} + 3'd1) : (3'd4 - {1'b0, s0});
    assign tgt_pc = {bus.bp_target[31:2], 2'b00};
    assign seq_pc = {pc_q[31:4] + 28'd1, 4'b0000};
    assign xfer   = bus.pc_valid && bus.ifu_ready && !bus.stall && !bus.redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q  <= {bus.redirect_pc[31:2], 2'b00};
            err_q <= |bus.redirect_pc[1:0];
        end else if (xfer) begin
            pc_q  <= eh ? tgt_pc : seq_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios followed by random traffic, all
// compared against a behavioural model of the fetch request stream.
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h1C000000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // model state: current request address, whether it is presented, error flag
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_err;

    fetch_pc_if bus ();

    fetch_pc_gen #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_taken(input logic [31:0] pc, input bit hit, input int slot);
        return hit && (slot >= int'(pc[3:2]));
    endfunction

    function automatic int m_count(input logic [31:0] pc, input bit hit, input int slot);
        if (m_taken(pc, hit, slot)) return slot - int'(pc[3:2]) + 1;
        return 4 - int'(pc[3:2]);
    endfunction

    // Called at a falling edge; drives inputs, checks outputs, advances the model
    // across the rising edge, and returns at the next falling edge.
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc,
                        input bit hit, input logic [1:0] slot, input logic [31:0] tgt,
                        input bit rdy);
        int cnt;
        bit tk;
        bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
        bus.bp_hit = hit; bus.bp_slot = slot; bus.bp_target = tgt; bus.ifu_ready = rdy;
        #1;
        cnt = m_count(m_pc, hit, int'(slot));
        tk  = m_taken(m_pc, hit, int'(slot));
        check("pc_valid", {31'b0, bus.pc_valid}, {31'b0, m_valid});
        check("fetch_pc", bus.fetch_pc, m_pc);
        check("misalign_err", {31'b0, bus.misalign_err}, {31'b0, m_err});
        check("cut_pos", {30'b0, bus.cut_pos}, 32'(cnt % 4));
        check("pred_taken", {31'b0, bus.pred_taken}, {31'b0, tk});
        check("pred_target", bus.pred_jump_target_pc, tk ? (tgt & 32'hFFFF_FFFC) : 32'h0);
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_valid = 0; m_err = 0;
        end else if (rv) begin
            m_pc = rpc & 32'hFFFF_FFFC; m_err = (rpc[1:0] != 2'b00); m_valid = 0;
        end else if (!m_valid) begin
            m_valid = 1;
        end else if (rdy && !st) begin
            m_pc = tk ? (tgt & 32'hFFFF_FFFC) : ((m_pc & 32'hFFFF_FFF0) + 32'h10);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 32'h0, 0, 2'd0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        m_pc = RESET_PC; m_valid = 0; m_err = 0;
        check("rst_pc", bus.fetch_pc, RESET_PC);
        check("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
        check("rst_err", {31'b0, bus.misalign_err}, 32'h0);
        idle(1);
        rst = 0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.bp_hit = 0; bus.bp_slot = 0; bus.bp_target = 0; bus.ifu_ready = 0;
        m_pc = RESET_PC; m_valid = 0; m_err = 0;
        @(negedge clk);
        do_reset();

        // sequential fetch after reset
        idle(1);
        check("boot_valid", {31'b0, bus.pc_valid}, 32'h1);
        check("seq0", bus.fetch_pc, 32'h1C000000);
        idle(1);
        check("seq1", bus.fetch_pc, 32'h1C000010);
        idle(1);
        check("seq2", bus.fetch_pc, 32'h1C000020);
        check("seq2_cut", {30'b0, bus.cut_pos}, 32'h0);

        // redirect into mid-group
        step(0, 1, 32'h1C000108, 0, 2'd0, 32'h0, 1);
        check("redir_bubble", {31'b0, bus.pc_valid}, 32'h0);
        idle(0);
        check("redir_pc", bus.fetch_pc, 32'h1C000108);
        check("redir_cut", {30'b0, bus.cut_pos}, 32'h2);
        idle(1);
        check("redir_next", bus.fetch_pc, 32'h1C000110);

        // predicted-taken branch in slot 3
        step(0, 1, 32'h1C000104, 0, 2'd0, 32'h0, 1);
        idle(0);
        step(0, 0, 32'h0, 1, 2'd3, 32'h1C002000, 1);
        check("bp_target_pc", bus.fetch_pc, 32'h1C002000);

        // hit before the start slot is ignored
        step(0, 1, 32'h1C00010C, 0, 2'd0, 32'h0, 1);
        idle(0);
        step(0, 0, 32'h0, 1, 2'd1, 32'h1C009000, 1);
        check("stale_hit_pc", bus.fetch_pc, 32'h1C000110);

        // backpressure hold, then a single advance
        repeat (5) idle(0);
        check("hold_pc", bus.fetch_pc, 32'h1C000110);
        idle(1);
        check("hold_advance", bus.fetch_pc, 32'h1C000120);

        // redirect under stall, misaligned
        step(1, 1, 32'h00002003, 0, 2'd0, 32'h0, 1);
        check("stall_redir_pc", bus.fetch_pc, 32'h00002000);
        check("stall_redir_err", {31'b0, bus.misalign_err}, 32'h1);
        repeat (3) step(1, 0, 32'h0, 0, 2'd0, 32'h0, 1);
        check("stall_hold", bus.fetch_pc, 32'h00002000);
        idle(1);
        check("stall_release", bus.fetch_pc, 32'h00002010);

        // back-to-back redirects: later one wins
        step(0, 1, 32'h00004000, 0, 2'd0, 32'h0, 1);
        step(0, 1, 32'h00005004, 0, 2'd0, 32'h0, 1);
        check("b2b_bubble", {31'b0, bus.pc_valid}, 32'h0);
        idle(1);
        check("b2b_pc", bus.fetch_pc, 32'h00005004);

        // wrap at the top of the address space
        step(0, 1, 32'hFFFFFFF0, 0, 2'd0, 32'h0, 1);
        idle(0);
        idle(1);
        check("wrap_pc", bus.fetch_pc, 32'h00000000);

        // reset mid-hold
        repeat (2) idle(0);
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rpc,
                     $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom,
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
